// File: rtl/sensor_distancia_defs.sv
// Constants shared by the ultrasonic distance controller and its downstream filter.
package sensor_distancia_defs;
  localparam logic [1:0] ENVIANDO_PULSO   = 2'b00;
  localparam logic [1:0] RECIBIENDO_PULSO = 2'b01;
  localparam logic [1:0] ESPERANDO_PULSO  = 2'b10;
  localparam logic [1:0] EN_ESPERA        = 2'b11;

  localparam int DIST_MAX_DEF = 400;
  localparam int DIST_W       = 9;

  typedef struct packed {
    logic muestra;
    logic timeout;
  } evento_t;
endpackage

// File: rtl/promedio_movil.sv
// Circular-buffer moving average over 2^LOG2_N samples with prefill and registered output.
module promedio_movil
  import sensor_distancia_defs::*;
#(
  parameter int LOG2_N = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              carga_i,
  input  logic              prefill_i,
  input  logic [DIST_W-1:0] dato_i,
  output logic [DIST_W-1:0] media_o,
  output logic [DIST_W-1:0] media_d_o,
  output logic              actualiza_o,
  output logic              valido_o
);
  localparam int N  = 1 << LOG2_N;
  localparam int SW = DIST_W + LOG2_N;

  logic [N-1:0][DIST_W-1:0] mem_q, mem_d;
  logic [SW-1:0]            sum_q, sum_d;
  logic [LOG2_N-1:0]        wp_q, wp_d;
  logic [1:0]               vld_pipe_q;
  logic [DIST_W-1:0]        media_q;

  always_comb begin
    mem_d = mem_q;
    sum_d = sum_q;
    wp_d  = wp_q;
    if (carga_i) begin
      if (prefill_i) begin
        for (int i = 0; i < N; i++) mem_d[i] = dato_i;
        sum_d = {dato_i, {LOG2_N{1'b0}}};
        wp_d  = '0;
      end else begin
        // Subtract the oldest entry before adding the new one; width covers the full window.
        sum_d      = sum_q - SW'(mem_q[wp_q]) + SW'(dato_i);
        mem_d[wp_q] = dato_i;
        wp_d       = wp_q + LOG2_N'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q      <= '0;
      sum_q      <= '0;
      wp_q       <= '0;
      vld_pipe_q <= '0;
      media_q    <= '0;
    end else begin
      mem_q      <= mem_d;
      sum_q      <= sum_d;
      wp_q       <= wp_d;
      vld_pipe_q <= {vld_pipe_q[0], carga_i};
      if (vld_pipe_q[0]) media_q <= media_d_o;
    end
  end

  assign media_d_o   = sum_q[SW-1:LOG2_N];
  assign actualiza_o = vld_pipe_q[0];
  assign valido_o    = vld_pipe_q[1];
  assign media_o     = media_q;
endmodule

// File: rtl/filtro_distancia.sv
// Decodes measurement/timeout events from the distance controller, rejects bad readings,
// averages good ones and derives hysteretic proximity and no-reading flags.
module filtro_distancia
  import sensor_distancia_defs::*;
#(
  parameter int LOG2_N       = 2,
  parameter int DIST_MAX     = DIST_MAX_DEF,
  parameter int UMBRAL_CERCA = 15,
  parameter int UMBRAL_LEJOS = 20,
  parameter int MAX_FALLOS   = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        estado_sensor,
  input  logic [DIST_W-1:0] distancia,
  output logic [DIST_W-1:0] distancia_filtrada,
  output logic              muestra_valida,
  output logic              objeto_cerca,
  output logic              sin_lectura
);
  localparam int FW = $clog2(MAX_FALLOS + 1);
  localparam logic [FW-1:0]     MAXF  = FW'(MAX_FALLOS);
  localparam logic [DIST_W-1:0] DMAX  = DIST_W'(DIST_MAX);
  localparam logic [DIST_W-1:0] CERCA = DIST_W'(UMBRAL_CERCA);
  localparam logic [DIST_W-1:0] LEJOS = DIST_W'(UMBRAL_LEJOS);

  logic [1:0]        estado_prev_q;
  logic [FW-1:0]     fallos_q, fallos_d;
  logic              sin_q, sin_d, cerca_q, cerca_d;
  evento_t           ev;
  logic              rechazo, ok, fallo, actualiza;
  logic [DIST_W-1:0] media_d;

  assign ev.muestra = (estado_prev_q == EN_ESPERA)       && (estado_sensor == ENVIANDO_PULSO);
  assign ev.timeout = (estado_prev_q == ESPERANDO_PULSO) && (estado_sensor == ENVIANDO_PULSO);
  assign rechazo    = (distancia == '0) || (distancia > DMAX);
  assign ok         = ev.muestra && !rechazo;
  assign fallo      = ev.timeout || (ev.muestra && rechazo);

  always_comb begin
    fallos_d = fallos_q;
    sin_d    = sin_q;
    cerca_d  = cerca_q;
    if (ok) begin
      fallos_d = '0;
      sin_d    = 1'b0;
    end else if (fallo) begin
      if (fallos_q != MAXF) fallos_d = fallos_q + FW'(1);
      if (fallos_d == MAXF) begin
        sin_d   = 1'b1;
        cerca_d = 1'b0;
      end
    end
    // Hysteresis is judged on the value being loaded into distancia_filtrada this edge.
    if (actualiza && !(fallo && fallos_d == MAXF)) begin
      if (media_d < CERCA)      cerca_d = 1'b1;
      else if (media_d > LEJOS) cerca_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_prev_q <= ENVIANDO_PULSO;
      fallos_q      <= '0;
      sin_q         <= 1'b1;
      cerca_q       <= 1'b0;
    end else begin
      estado_prev_q <= estado_sensor;
      fallos_q      <= fallos_d;
      sin_q         <= sin_d;
      cerca_q       <= cerca_d;
    end
  end

  promedio_movil #(.LOG2_N(LOG2_N)) u_promedio (
    .clk         (clk),
    .reset       (reset),
    .carga_i     (ok),
    .prefill_i   (sin_q),
    .dato_i      (distancia),
    .media_o     (distancia_filtrada),
    .media_d_o   (media_d),
    .actualiza_o (actualiza),
    .valido_o    (muestra_valida)
  );

  assign objeto_cerca = cerca_q;
  assign sin_lectura  = sin_q;
endmodule
